fpu_writeback_ctrl: RTL and testbench

- Write-side partner of the FP register file.
- Accepts completed FPU results over a valid/ready handshake and buffers them in a small FIFO.
- Drives the register file's write port (f_w_data, f_rd, f_wen) and its exception-flag inputs (f_NV, f_DZ, f_OF, f_UF, f_NX).
- Keeps a 32-entry pending-destination scoreboard that stalls control-unit issue on RAW/WAW hazards against in-flight FP results.

---
 rtl/fpu_writeback_ctrl.sv | 110 +++++++++++
 tb/tb_fpu_writeback_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_writeback_ctrl.sv
// FP writeback controller: buffers FPU results, drives the FP register file write port,
// and keeps a pending-destination scoreboard. Define FPU_FLAG_ACCUM_EN for sticky flag accumulation.
module fpu_writeback_ctrl #(
    parameter int DEPTH = 2,
    parameter int NREGS = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    output logic        issue_stall,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [4:0]  res_rd,
    input  logic [31:0] res_data,
    input  logic [4:0]  res_flags,
    input  logic        wb_stall,
    input  logic        flush,
    output logic [31:0] f_w_data,
    output logic [4:0]  f_rd,
    output logic        f_wen,
    output logic        f_NV,
    output logic        f_DZ,
    output logic        f_OF,
    output logic        f_UF,
    output logic        f_NX,
`ifdef FPU_FLAG_ACCUM_EN
    output logic [4:0]  fflags_acc,
    input  logic        fflags_clr,
`endif
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flags;
    } ent_t;

    ent_t             mem [DEPTH];
    ent_t             head;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [NREGS-1:0] pend, pend_nxt;
    logic             empty, full, enq, deq, iss;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    // Outputs are gated by RST so they read as idle before the first reset edge.
    assign f_wen       = !RST && !empty && !wb_stall && !flush;
    assign f_w_data    = (RST || empty) ? '0 : head.data;
    assign f_rd        = (RST || empty) ? '0 : head.rd;
    assign {f_NV, f_DZ, f_OF, f_UF, f_NX} = f_wen ? head.flags : 5'b0;
    assign res_ready   = RST || !full;
    assign issue_stall = !RST && issue_valid &&
                         (pend[issue_rd] || pend[issue_rs1] || pend[issue_rs2]);
    assign busy        = !RST && (!empty || (|pend));

    assign enq = !RST && res_valid && !full && !flush;
    assign deq = f_wen;
    assign iss = issue_valid && !issue_stall && !flush;

    // Clear-then-set ordering is safe: an rd that is pending always stalls issue.
    always_comb begin
        pend_nxt = pend;
        if (deq) pend_nxt[head.rd] = 1'b0;
        if (iss) pend_nxt[issue_rd] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pend   <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
            pend   <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pend <= pend_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq) mem[wr_ptr] <= '{rd: res_rd, data: res_data, flags: res_flags};
    end

`ifdef FPU_FLAG_ACCUM_EN
    // Sticky flags survive flush; a same-cycle clear keeps only the retiring flags.
    always_ff @(posedge CLK) begin
        if (RST) fflags_acc <= '0;
        else     fflags_acc <= (fflags_clr ? 5'b0 : fflags_acc) | (f_wen ? head.flags : 5'b0);
    end
`endif

endmodule

// File: tb/tb_fpu_writeback_ctrl.sv
// Bench for fpu_writeback_ctrl: directed vector table, hand sequences, and random
// stimulus checked against a queue-based reference model.
module tb_fpu_writeback_ctrl;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_stall, res_valid, res_ready, wb_stall, flush, f_wen, busy;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2, res_rd, res_flags, f_rd;
    logic [31:0] res_data, f_w_data;
    logic        f_NV, f_DZ, f_OF, f_UF, f_NX;
`ifdef FPU_FLAG_ACCUM_EN
    logic [4:0]  fflags_acc;
    logic        fflags_clr;
`endif

    always #5 clk = ~clk;

    fpu_writeback_ctrl #(.DEPTH(DEPTH), .NREGS(32)) dut (
        .CLK(clk), .RST(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_stall(issue_stall),
        .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd),
        .res_data(res_data), .res_flags(res_flags),
        .wb_stall(wb_stall), .flush(flush),
        .f_w_data(f_w_data), .f_rd(f_rd), .f_wen(f_wen),
        .f_NV(f_NV), .f_DZ(f_DZ), .f_OF(f_OF), .f_UF(f_UF), .f_NX(f_NX),
`ifdef FPU_FLAG_ACCUM_EN
        .fflags_acc(fflags_acc), .fflags_clr(fflags_clr),
`endif
        .busy(busy)
    );

    typedef struct packed {
        logic        iv;
        logic [4:0]  ird, irs1, irs2;
        logic        rv;
        logic [4:0]  rrd;
        logic [31:0] rdata;
        logic [4:0]  rfl;
        logic        wbs, fl, clr;
    } in_t;

    typedef struct packed {
        in_t         i;
        logic        stall, ready, wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  fl;
        logic        busy;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flags;
    } res_t;

    int          n_chk = 0, n_fail = 0;
    res_t        q[$];
    logic [31:0] pend_m;
    logic [4:0]  acc_m;
    in_t         cur;
    logic        e_stall, e_ready, e_wen, e_busy;
    logic [4:0]  e_rd, e_fl;
    logic [31:0] e_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t I(input logic iv, input logic [4:0] ird, irs1, irs2,
                              input logic rv, input logic [4:0] rrd, input logic [31:0] rdata,
                              input logic [4:0] rfl, input logic wbs, fl, clr);
        in_t s;
        s = '{iv, ird, irs1, irs2, rv, rrd, rdata, rfl, wbs, fl, clr};
        return s;
    endfunction

    function automatic vec_t V(input in_t s, input logic st, rdy, wen, input logic [4:0] rd,
                               input logic [31:0] data, input logic [4:0] fl, input logic bsy);
        vec_t v;
        v = '{s, st, rdy, wen, rd, data, fl, bsy};
        return v;
    endfunction

    // Drive one cycle's inputs, then compare outputs with the model mid-cycle.
    task automatic apply(input in_t s);
        cur = s;
        issue_valid = s.iv; issue_rd = s.ird; issue_rs1 = s.irs1; issue_rs2 = s.irs2;
        res_valid = s.rv; res_rd = s.rrd; res_data = s.rdata; res_flags = s.rfl;
        wb_stall = s.wbs; flush = s.fl;
`ifdef FPU_FLAG_ACCUM_EN
        fflags_clr = s.clr;
`endif
        #4;
        e_ready = q.size() < DEPTH;
        e_wen   = q.size() != 0 && !s.wbs && !s.fl;
        e_rd    = q.size() != 0 ? q[0].rd : 5'd0;
        e_data  = q.size() != 0 ? q[0].data : 32'd0;
        e_fl    = e_wen ? q[0].flags : 5'd0;
        e_stall = s.iv && (pend_m[s.ird] || pend_m[s.irs1] || pend_m[s.irs2]);
        e_busy  = q.size() != 0 || pend_m != 0;
        chk("m_ready", res_ready, e_ready);
        chk("m_wen", f_wen, e_wen);
        chk("m_rd", f_rd, e_rd);
        chk("m_data", f_w_data, e_data);
        chk("m_flags", {f_NV, f_DZ, f_OF, f_UF, f_NX}, e_fl);
        chk("m_stall", issue_stall, e_stall);
        chk("m_busy", busy, e_busy);
`ifdef FPU_FLAG_ACCUM_EN
        chk("m_acc", fflags_acc, acc_m);
`endif
    endtask

    task automatic tick();
        acc_m = (cur.clr ? 5'd0 : acc_m) | e_fl;
        if (cur.fl) begin
            q.delete();
            pend_m = '0;
        end else begin
            if (e_wen) begin
                pend_m[q[0].rd] = 1'b0;
                void'(q.pop_front());
            end
            if (cur.rv && e_ready) q.push_back('{cur.rrd, cur.rdata, cur.rfl});
            if (cur.iv && !e_stall) pend_m[cur.ird] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    vec_t tab[16];
    in_t  idle;

    initial begin
        idle = '0;
        //          iv ird rs1 rs2 rv rrd data          fl      wbs fl clr   stall rdy wen rd data fl busy
        tab[0]  = V(I(1, 5, 1, 2, 0, 0, 0, 0, 0, 0, 0),                   0, 1, 0, 0, 0, 0, 0);
        tab[1]  = V(I(0, 0, 0, 0, 1, 5, 32'h3F800000, 5'b00001, 0, 0, 0), 0, 1, 0, 0, 0, 0, 1);
        tab[2]  = V(idle,                                    0, 1, 1, 5, 32'h3F800000, 5'b00001, 1);
        tab[3]  = V(idle,                                    0, 1, 0, 0, 0, 0, 0);
        tab[4]  = V(I(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0),                   0, 1, 0, 0, 0, 0, 0);
        tab[5]  = V(I(1, 7, 5, 6, 1, 5, 32'h40000000, 0, 0, 0, 0),        1, 1, 0, 0, 0, 0, 1);
        tab[6]  = V(I(1, 7, 5, 6, 0, 0, 0, 0, 0, 0, 0),      1, 1, 1, 5, 32'h40000000, 0, 1);
        tab[7]  = V(I(1, 7, 5, 6, 0, 0, 0, 0, 0, 0, 0),                   0, 1, 0, 0, 0, 0, 0);
        tab[8]  = V(I(0, 0, 0, 0, 1, 7, 32'h11111111, 5'b10000, 0, 0, 0), 0, 1, 0, 0, 0, 0, 1);
        tab[9]  = V(idle,                                    0, 1, 1, 7, 32'h11111111, 5'b10000, 1);
        tab[10] = V(idle,                                    0, 1, 0, 0, 0, 0, 0);
        tab[11] = V(I(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),                   0, 1, 0, 0, 0, 0, 0);
        tab[12] = V(I(1, 2, 0, 0, 1, 1, 32'hAAAA0001, 0, 1, 0, 0),        0, 1, 0, 0, 0, 0, 1);
        tab[13] = V(I(1, 3, 0, 0, 1, 2, 32'hBBBB0002, 0, 1, 0, 0), 0, 1, 0, 1, 32'hAAAA0001, 0, 1);
        tab[14] = V(I(1, 9, 0, 0, 1, 3, 32'hCCCC0003, 0, 0, 1, 0), 0, 0, 0, 1, 32'hAAAA0001, 0, 1);
        tab[15] = V(idle,                                    0, 1, 0, 0, 0, 0, 0);

        // Reset: outputs must be idle while RST is held.
        rst = 1'b1;
        issue_valid = 1'b1; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        res_valid = 0; res_rd = 0; res_data = 0; res_flags = 0; wb_stall = 0; flush = 0;
`ifdef FPU_FLAG_ACCUM_EN
        fflags_clr = 0;
`endif
        @(posedge clk); #1;
        #4;
        chk("rst_wen", f_wen, 0);
        chk("rst_data", f_w_data, 0);
        chk("rst_rd", f_rd, 0);
        chk("rst_flags", {f_NV, f_DZ, f_OF, f_UF, f_NX}, 0);
        chk("rst_stall", issue_stall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", res_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); pend_m = '0; acc_m = '0;

        for (int k = 0; k < 16; k++) begin
            apply(tab[k].i);
            chk($sformatf("v%0d_stall", k), issue_stall, tab[k].stall);
            chk($sformatf("v%0d_ready", k), res_ready, tab[k].ready);
            chk($sformatf("v%0d_wen", k), f_wen, tab[k].wen);
            chk($sformatf("v%0d_rd", k), f_rd, tab[k].rd);
            chk($sformatf("v%0d_data", k), f_w_data, tab[k].data);
            chk($sformatf("v%0d_flags", k), {f_NV, f_DZ, f_OF, f_UF, f_NX}, tab[k].fl);
            chk($sformatf("v%0d_busy", k), busy, tab[k].busy);
            tick();
        end

        // wb_stall holds the head; producer keeps the third result valid until taken.
        for (int c = 0; c < 8; c++) begin
            logic [4:0] rd_o;
            rd_o = (c < 2) ? 5'(10 + c) : 5'd12;
            apply(I(0, 0, 0, 0, c < 6, rd_o, 32'hD000_0000 + 32'(rd_o), 0, c < 4, 0, 0));
            if (c == 2) chk("wbs_ready_full", res_ready, 0);
            if (c == 4) chk("wbs_first_out", f_w_data, 32'hD000_000A);
            if (c == 6) chk("wbs_third_out", f_w_data, 32'hD000_000C);
            tick();
        end

        // Steady state at count=1: one in, one out each cycle.
        for (int k = 0; k <= 11; k++) begin
            apply(I(0, 0, 0, 0, k < 11, 5'(16 + k), 32'h100 + 32'(k), 0, 0, 0, 0));
            if (k > 0) begin
                chk("c1_wen", f_wen, 1);
                chk("c1_data", f_w_data, 32'h100 + 32'(k - 1));
            end
            tick();
        end

`ifdef FPU_FLAG_ACCUM_EN
        apply(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); tick();
        apply(I(0, 0, 0, 0, 1, 1, 1, 5'b10000, 0, 0, 0)); tick();
        apply(I(0, 0, 0, 0, 1, 2, 2, 5'b00100, 0, 0, 0)); tick();
        apply(idle); tick();
        apply(idle); chk("acc_or", fflags_acc, 5'b10100); tick();
        apply(I(0, 0, 0, 0, 1, 3, 3, 5'b00001, 0, 0, 0)); tick();
        apply(I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); tick();
        apply(idle); chk("acc_clr_wr", fflags_acc, 5'b00001); tick();
`endif

        for (int k = 0; k < 600; k++) begin
            in_t s;
            s.iv = 1'($urandom_range(0, 1));
            s.ird = 5'($urandom_range(0, 7)); s.irs1 = 5'($urandom_range(0, 7));
            s.irs2 = 5'($urandom_range(0, 7));
            s.rv = ($urandom_range(0, 3) != 0);
            s.rrd = 5'($urandom_range(0, 7)); s.rdata = $urandom; s.rfl = 5'($urandom_range(0, 31));
            s.wbs = ($urandom_range(0, 3) == 0);
            s.fl = ($urandom_range(0, 31) == 0);
            s.clr = ($urandom_range(0, 7) == 0);
            apply(s);
            tick();
        end

        // Reset mid-operation loses in-flight state.
        apply(I(1, 20, 0, 0, 1, 4, 32'h55, 1, 1, 0, 0)); tick();
        apply(I(0, 0, 0, 0, 1, 5, 32'h66, 1, 1, 0, 0)); tick();
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        q.delete(); pend_m = '0; acc_m = '0;
        apply(idle);
        chk("midrst_busy", busy, 0);
        chk("midrst_wen", f_wen, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
